// File: rtl/bank_scan_reader.sv
// bank_scan_reader
// Snapshots a bank of NUM_CH DATA_W-bit registers on start and streams the
// entries out in order (channel 1..NUM_CH) on a valid/ready port, each tagged
// with its channel number. A one-cycle done pulse follows the last transfer.
//
// Build option: SCAN_PARITY_EN -- when defined, out_parity carries the even
// parity of out_data, registered in the same cycle; when undefined it is tied 0.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   start      request a scan (sampled only in IDLE)
//   in_bus     bank contents, entry 1 in the LSBs
//   out_data   current entry from the snapshot
//   out_sel    channel tag 1..NUM_CH, 0 when no entry is presented
//   out_parity even parity of out_data (0 without SCAN_PARITY_EN)
//   out_valid  out_data/out_sel/out_parity valid
//   out_ready  consumer accepts; transfer = out_valid & out_ready
//   busy       scan in progress (SEND or DONE)
//   done       one-cycle pulse after the last transfer
//
// state | meaning
// IDLE  | waiting for start, outputs quiet
// SEND  | presenting entry idx, advancing on each transfer
// DONE  | one-cycle done pulse, then back to IDLE

module bank_scan_reader #(
  parameter int DATA_W = 7,
  parameter int NUM_CH = 7,
  parameter int SEL_W  = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [NUM_CH*DATA_W-1:0] in_bus,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_sel,
  output logic                     out_parity,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] snap [NUM_CH];
  logic [SEL_W-1:0]  idx;
  logic [SEL_W-1:0]  idx_nxt;

  logic [DATA_W-1:0] data_d;
  logic [SEL_W-1:0]  sel_d;
  logic [SEL_W-1:0]  idx_d;
  logic              valid_d;
  logic              busy_d;
  logic              done_d;
  logic              load_snap;

  logic xfer;
  logic last;

  assign xfer    = out_valid & out_ready;
  assign last    = (idx == SEL_W'(NUM_CH - 1));
  assign idx_nxt = idx + SEL_W'(1);

  // State, output and snapshot registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      idx       <= '0;
      out_data  <= '0;
      out_sel   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) snap[i] <= '0;
    end else begin
      state_q   <= state_d;
      idx       <= idx_d;
      out_data  <= data_d;
      out_sel   <= sel_d;
      out_valid <= valid_d;
      busy      <= busy_d;
      done      <= done_d;
      if (load_snap) begin
        for (int i = 0; i < NUM_CH; i++) snap[i] <= in_bus[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SEND;
      S_SEND:  if (xfer && last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    data_d    = out_data;
    sel_d     = out_sel;
    idx_d     = idx;
    valid_d   = out_valid;
    busy_d    = busy;
    done_d    = 1'b0;
    load_snap = 1'b0;
    case (state_q)
      S_IDLE: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        sel_d   = '0;
        if (start) begin
          // Entry 1 comes straight off the bus: the snapshot loads on this same edge.
          load_snap = 1'b1;
          idx_d     = '0;
          data_d    = in_bus[DATA_W-1:0];
          sel_d     = SEL_W'(1);
          valid_d   = 1'b1;
          busy_d    = 1'b1;
        end
      end
      S_SEND: begin
        if (xfer) begin
          if (last) begin
            valid_d = 1'b0;
            sel_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d  = idx_nxt;
            data_d = snap[idx_nxt];
            sel_d  = idx_nxt + SEL_W'(1);
          end
        end
      end
      S_DONE: begin
        busy_d = 1'b0;
      end
      default: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        sel_d   = '0;
      end
    endcase
  end

`ifdef SCAN_PARITY_EN
  always_ff @(posedge clk) begin
    if (!reset) out_parity <= 1'b0;
    else        out_parity <= ^data_d;
  end
`else
  assign out_parity = 1'b0;
`endif

endmodule

// File: tb/tb_bank_scan_reader.sv
module tb_bank_scan_reader;

  localparam int DATA_W = 7;
  localparam int NUM_CH = 7;
  localparam int SEL_W  = 3;
  localparam int BUS_W  = NUM_CH * DATA_W;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [BUS_W-1:0] in_bus;
  logic [DATA_W-1:0] out_data;
  logic [SEL_W-1:0] out_sel;
  logic             out_parity;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             done;

  bank_scan_reader #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .SEL_W(SEL_W)) dut (
    .clk(clk), .reset(reset), .start(start), .in_bus(in_bus),
    .out_data(out_data), .out_sel(out_sel), .out_parity(out_parity),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] data;
    logic              par;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic [BUS_W-1:0] bus;
    int               stall_entry;
    int               stall_n;
    bit               hold_start;
    bit               corrupt;
  } vec_t;

  vec_t vt[5];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic exp_par(logic [DATA_W-1:0] d);
`ifdef SCAN_PARITY_EN
    return ^d;
`else
    return 1'b0;
`endif
  endfunction

  function automatic void push_entries(logic [BUS_W-1:0] bus, int first, int last_e);
    exp_t e;
    for (int i = first; i <= last_e; i++) begin
      e.data = bus[(i-1)*DATA_W +: DATA_W];
      e.sel  = SEL_W'(i);
      e.par  = exp_par(e.data);
      sb.push_back(e);
    end
  endfunction

  // Scoreboard monitor plus hold-stable check under backpressure
  logic              stalled = 1'b0;
  logic [DATA_W-1:0] st_data;
  logic [SEL_W-1:0]  st_sel;

  always @(negedge clk) begin
    exp_t e;
    if (stalled) begin
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_data", {25'd0, out_data}, {25'd0, st_data});
      check("stall_sel", {29'd0, out_sel}, {29'd0, st_sel});
    end
    stalled = out_valid && !out_ready && reset;
    st_data = out_data;
    st_sel  = out_sel;
    if (reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_xfer_sel", {29'd0, out_sel}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("xfer_sel", {29'd0, out_sel}, {29'd0, e.sel});
        check("xfer_data", {25'd0, out_data}, {25'd0, e.data});
        check("xfer_parity", {31'd0, out_parity}, {31'd0, e.par});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full scan driven from start; out_ready deasserted for stall_n cycles on stall_entry.
  task automatic run_scan(vec_t v);
    int cyc;
    int stall_left;
    stall_left = v.stall_n;
    push_entries(v.bus, 1, NUM_CH);
    in_bus    = v.bus;
    out_ready = 1'b1;
    start     = 1'b1;
    step();
    if (!v.hold_start) start = 1'b0;
    if (v.corrupt) in_bus = {NUM_CH{7'h7F}};
    check("start_latency_valid", {31'd0, out_valid}, 32'd1);
    check("start_latency_sel", {29'd0, out_sel}, 32'd1);
    check("start_busy", {31'd0, busy}, 32'd1);
    cyc = 1;
    while (!done && cyc < 40) begin
      if (int'(out_sel) == v.stall_entry && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = 1'b1;
      end
      step();
      cyc++;
    end
    start = 1'b0;
    check("scan_length", cyc, 8 + v.stall_n);
    check("done_busy", {31'd0, busy}, 32'd1);
    check("done_valid", {31'd0, out_valid}, 32'd0);
    check("done_sel", {29'd0, out_sel}, 32'd0);
    check("done_data_held", {25'd0, out_data}, {25'd0, v.bus[BUS_W-1 -: DATA_W]});
    step();
    check("after_done", {30'd0, busy, done}, 32'd0);
    check("after_valid", {31'd0, out_valid}, 32'd0);
    check("sb_empty", sb.size(), 0);
    step();
    check("idle_valid", {31'd0, out_valid}, 32'd0);
  endtask

  logic [BUS_W-1:0] bus_a;

  initial begin
    bus_a = {7'h67, 7'h56, 7'h45, 7'h34, 7'h23, 7'h12, 7'h01};
    vt[0] = '{bus: bus_a, stall_entry: 0, stall_n: 0, hold_start: 1'b0, corrupt: 1'b0};
    vt[1] = '{bus: bus_a, stall_entry: 3, stall_n: 3, hold_start: 1'b0, corrupt: 1'b0};
    vt[2] = '{bus: bus_a, stall_entry: 0, stall_n: 0, hold_start: 1'b1, corrupt: 1'b1};
    vt[3] = '{bus: {7'h01, 7'h2A, 7'h55, 7'h7F, 7'h00, 7'h03, 7'h07},
              stall_entry: 7, stall_n: 2, hold_start: 1'b0, corrupt: 1'b0};
    vt[4] = '{bus: {7'h1F, 7'h6E, 7'h5D, 7'h4C, 7'h3B, 7'h2A, 7'h19},
              stall_entry: 1, stall_n: 1, hold_start: 1'b1, corrupt: 1'b0};

    reset = 1'b0; start = 1'b1; out_ready = 1'b1; in_bus = bus_a;
    for (int i = 0; i < 4; i++) step();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sel", {29'd0, out_sel}, 32'd0);
    check("rst_data", {25'd0, out_data}, 32'd0);
    check("rst_parity", {31'd0, out_parity}, 32'd0);
    start = 1'b0;
    reset = 1'b1;
    step();
    check("idle_no_start", {30'd0, out_valid, busy}, 32'd0);

    for (int k = 0; k < 5; k++) run_scan(vt[k]);

    // Back-to-back scans with start held, then a reset on entry 4
    push_entries(bus_a, 1, NUM_CH);
    in_bus = bus_a; out_ready = 1'b1; start = 1'b1;
    step();
    for (int c = 0; c < 40 && !done; c++) step();
    check("b2b_done", {31'd0, done}, 32'd1);
    step();
    check("b2b_gap_valid", {31'd0, out_valid}, 32'd0);
    check("b2b_gap_busy", {31'd0, busy}, 32'd0);
    push_entries(bus_a, 1, 3);
    step();
    start = 1'b0;
    check("b2b_restart_valid", {31'd0, out_valid}, 32'd1);
    check("b2b_restart_sel", {29'd0, out_sel}, 32'd1);
    for (int i = 0; i < 3; i++) step();
    check("pre_rst_sel", {29'd0, out_sel}, 32'd4);
    check("pre_rst_data", {25'd0, out_data}, 32'h34);
    out_ready = 1'b0;
    reset = 1'b0;
    step();
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_sel", {29'd0, out_sel}, 32'd0);
    check("midrst_data", {25'd0, out_data}, 32'd0);
    check("midrst_busy_done", {30'd0, busy, done}, 32'd0);
    check("midrst_parity", {31'd0, out_parity}, 32'd0);
    check("midrst_sb_empty", sb.size(), 0);
    reset = 1'b1;
    out_ready = 1'b1;
    step();
    run_scan(vt[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
